// File: rtl/raiz_cuadrada_seq.sv
// Sequential integer square root: non-restoring recurrence, one root bit per clock,
// followed by a single fix-up/rounding cycle. One operation in flight at a time.
module raiz_cuadrada_seq #(
  parameter int WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic [WIDTH-1:0]     radicand,
  input  logic                 round,
  output logic                 busy,
  output logic                 done,
  output logic [WIDTH/2-1:0]   root,
  output logic [WIDTH/2:0]     remainder,
  output logic                 sat
);

  localparam int N     = WIDTH / 2;
  localparam int CNT_W = $clog2(N) + 1;

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIX, S_DONE} state_t;

  state_t                  r_state;
  state_t                  w_state_nxt;
  logic                    w_accept;

  logic [WIDTH-1:0]        r_x;
  logic                    r_rnd;
  logic signed [N+1:0]     r_pr;
  logic [N-1:0]            r_q;
  logic [CNT_W-1:0]        r_cnt;

  logic [N-1:0]            r_root;
  logic [N:0]              r_rem;
  logic                    r_sat;

  logic signed [N+1:0]     w_pr_sh;
  logic signed [N+1:0]     w_pr_it;
  logic [N-1:0]            w_q_it;
  logic [N:0]              w_rem_fix;
  logic                    w_up;
  logic                    w_sat;
  logic [N-1:0]            w_root_out;

  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_state_nxt = S_CALC;
          w_accept    = 1'b1;
        end
      end
      S_CALC: begin
        if (r_cnt == CNT_W'(N - 1)) w_state_nxt = S_FIX;
      end
      S_FIX:  w_state_nxt = S_DONE;
      S_DONE: begin
        if (start) begin
          w_state_nxt = S_CALC;
          w_accept    = 1'b1;
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Iteration: the partial remainder only ever needs N+2 bits, so the wider
  // intermediate shift wraps harmlessly in modular arithmetic.
  always_comb begin
    w_pr_sh = {r_pr[N-1:0], r_x[WIDTH-1 -: 2]};
    if (r_pr[N+1]) w_pr_it = w_pr_sh + {r_q, 2'b11};
    else           w_pr_it = w_pr_sh - {r_q, 2'b01};
    w_q_it = {r_q[N-2:0], ~w_pr_it[N+1]};
  end

  // Fix-up: the corrected remainder is non-negative and below 2^(N+1).
  always_comb begin
    w_rem_fix  = r_pr[N:0] + (r_pr[N+1] ? {r_q, 1'b1} : {(N+1){1'b0}});
    w_up       = r_rnd && (w_rem_fix > {1'b0, r_q});
    w_sat      = w_up && (&r_q);
    w_root_out = (w_up && !w_sat) ? r_q + 1'b1 : r_q;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= S_IDLE;
      r_x     <= '0;
      r_rnd   <= 1'b0;
      r_pr    <= '0;
      r_q     <= '0;
      r_cnt   <= '0;
      r_root  <= '0;
      r_rem   <= '0;
      r_sat   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (w_accept) begin
        r_x   <= radicand;
        r_rnd <= round;
        r_pr  <= '0;
        r_q   <= '0;
        r_cnt <= '0;
      end else if (r_state == S_CALC) begin
        r_pr  <= w_pr_it;
        r_q   <= w_q_it;
        r_x   <= r_x << 2;
        r_cnt <= r_cnt + 1'b1;
      end else if (r_state == S_FIX) begin
        r_root <= w_root_out;
        r_rem  <= w_rem_fix;
        r_sat  <= w_sat;
      end
    end
  end

  assign busy      = (r_state == S_CALC) || (r_state == S_FIX);
  assign done      = (r_state == S_DONE);
  assign root      = r_root;
  assign remainder = r_rem;
  assign sat       = r_sat;

endmodule
